// File: rtl/fb_pkg.sv
// Shared widths, default resolution and FSM state type for the frame-buffer draw sequencer.
// The clear pass is built only when FB_DRAW_CLEAR_EN is defined.
package fb_pkg;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    localparam int COLOR_W   = 3;
    localparam int X_W       = 10;
    localparam int Y_W       = 9;

    localparam logic [COLOR_W-1:0] CLEAR_COLOR_DEF = 3'b000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DRAW  = 2'd2,
        SWAP  = 2'd3
    } fb_state_e;

endpackage

// File: rtl/fb_clear_scanner.sv
// Raster-order x/y address counter used by the clear pass: x fastest, wraps to (0,0)
// after the last pixel; last_o flags (H_RES-1, V_RES-1).
module fb_clear_scanner
    import fb_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en_i,
    input  logic           clr_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           last_o
);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           x_end;

    assign x_end  = (x_q == X_W'(H_RES - 1));
    assign last_o = x_end && (y_q == Y_W'(V_RES - 1));
    assign x_o    = x_q;
    assign y_o    = y_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr_i) begin
            x_d = '0;
            y_d = '0;
        end else if (en_i) begin
            if (x_end) begin
                x_d = '0;
                y_d = last_o ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/fb_draw_sequencer.sv
// Owns the back-buffer write port for one frame: optional clear, rasterizer draw, then swap.
// Define FB_DRAW_CLEAR_EN to build the CLEAR pass; otherwise frames start directly in DRAW.
module fb_draw_sequencer
    import fb_pkg::*;
#(
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF
`ifdef FB_DRAW_CLEAR_EN
    ,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = CLEAR_COLOR_DEF
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               rast_pixel_rdy,
    input  logic [X_W-1:0]     rast_x,
    input  logic [Y_W-1:0]     rast_y,
    input  logic [COLOR_W-1:0] rast_color,
    input  logic               rast_done,
    output logic               rast_pixel_ack,
    output logic               rast_enable,
    output logic               fb_wr_en,
    output logic [X_W-1:0]     fb_wr_x,
    output logic [Y_W-1:0]     fb_wr_y,
    output logic [COLOR_W-1:0] fb_wr_color,
    output logic               fb_swap_req,
    input  logic               fb_swap_done,
    output logic               busy,
    output logic               oob_err
);

    // Handshake: a pixel transfers in any DRAW cycle with rast_pixel_rdy high; ack is that
    // same-cycle condition, and the write follows one cycle later from registered fields.

`ifdef FB_DRAW_CLEAR_EN
    localparam fb_state_e START_ST = CLEAR;
`else
    localparam fb_state_e START_ST = DRAW;
`endif

    fb_state_e          state_q, state_d;
    logic               pend_q, pend_d;
    logic               oob_q, oob_d;
    logic               pix_en_q, pix_en_d;
    logic [X_W-1:0]     pix_x_q, pix_x_d;
    logic [Y_W-1:0]     pix_y_q, pix_y_d;
    logic [COLOR_W-1:0] pix_c_q, pix_c_d;
    logic               xfer, in_range, swap_take;

    assign xfer      = (state_q == DRAW) && rast_pixel_rdy;
    assign in_range  = (int'(rast_x) < H_RES) && (int'(rast_y) < V_RES);
    assign swap_take = (state_q == SWAP) && fb_swap_done;

`ifdef FB_DRAW_CLEAR_EN
    logic [X_W-1:0] clr_x;
    logic [Y_W-1:0] clr_y;
    logic           clr_last;

    fb_clear_scanner #(
        .H_RES(H_RES),
        .V_RES(V_RES)
    ) u_scanner (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (state_q == CLEAR),
        .clr_i (state_q != CLEAR),
        .x_o   (clr_x),
        .y_o   (clr_y),
        .last_o(clr_last)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pend_q   <= 1'b0;
            oob_q    <= 1'b0;
            pix_en_q <= 1'b0;
            pix_x_q  <= '0;
            pix_y_q  <= '0;
            pix_c_q  <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            oob_q    <= oob_d;
            pix_en_q <= pix_en_d;
            pix_x_q  <= pix_x_d;
            pix_y_q  <= pix_y_d;
            pix_c_q  <= pix_c_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        oob_d    = oob_q | (xfer & ~in_range);
        pix_en_d = xfer & in_range;
        pix_x_d  = pix_x_q;
        pix_y_d  = pix_y_q;
        pix_c_d  = pix_c_q;
        if (xfer && in_range) begin
            pix_x_d = rast_x;
            pix_y_d = rast_y;
            pix_c_d = rast_color;
        end
        case (state_q)
            IDLE: if (frame_start) state_d = START_ST;
`ifdef FB_DRAW_CLEAR_EN
            CLEAR: if (clr_last) state_d = DRAW;
`endif
            DRAW: if (rast_done) state_d = SWAP;
            SWAP: if (fb_swap_done) state_d = (pend_q || frame_start) ? START_ST : IDLE;
            default: state_d = IDLE;
        endcase
        // One-deep request memory; a start arriving with the swap itself is honoured directly.
        if (swap_take) pend_d = 1'b0;
        else if (frame_start && state_q != IDLE) pend_d = 1'b1;
    end

    always_comb begin
        rast_enable    = (state_q == DRAW);
        rast_pixel_ack = xfer;
        fb_swap_req    = (state_q == SWAP);
        busy           = (state_q != IDLE);
        oob_err        = oob_q;
        fb_wr_en       = pix_en_q;
        fb_wr_x        = pix_x_q;
        fb_wr_y        = pix_y_q;
        fb_wr_color    = pix_c_q;
`ifdef FB_DRAW_CLEAR_EN
        if (state_q == CLEAR) begin
            fb_wr_en    = 1'b1;
            fb_wr_x     = clr_x;
            fb_wr_y     = clr_y;
            fb_wr_color = CLEAR_COLOR;
        end
`endif
    end

endmodule

// File: tb/tb_fb_draw_sequencer.sv
// Directed bench for fb_draw_sequencer at a 4x2 frame; covers both FB_DRAW_CLEAR_EN builds.
module tb_fb_draw_sequencer;
  import fb_pkg::*;

  localparam int H = 4;
  localparam int V = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               frame_start = 1'b0;
  logic               rast_pixel_rdy = 1'b0;
  logic [X_W-1:0]     rast_x = '0;
  logic [Y_W-1:0]     rast_y = '0;
  logic [COLOR_W-1:0] rast_color = '0;
  logic               rast_done = 1'b0;
  logic               rast_pixel_ack, rast_enable, fb_wr_en, fb_swap_req, busy, oob_err;
  logic [X_W-1:0]     fb_wr_x;
  logic [Y_W-1:0]     fb_wr_y;
  logic [COLOR_W-1:0] fb_wr_color;
  logic               fb_swap_done = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [X_W+Y_W+COLOR_W-1:0] exp_q[$];

  fb_draw_sequencer #(.H_RES(H), .V_RES(V)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start   (frame_start),
    .rast_pixel_rdy(rast_pixel_rdy),
    .rast_x        (rast_x),
    .rast_y        (rast_y),
    .rast_color    (rast_color),
    .rast_done     (rast_done),
    .rast_pixel_ack(rast_pixel_ack),
    .rast_enable   (rast_enable),
    .fb_wr_en      (fb_wr_en),
    .fb_wr_x       (fb_wr_x),
    .fb_wr_y       (fb_wr_y),
    .fb_wr_color   (fb_wr_color),
    .fb_swap_req   (fb_swap_req),
    .fb_swap_done  (fb_swap_done),
    .busy          (busy),
    .oob_err       (oob_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_rast_en"}, 32'(rast_enable), 0);
    chk({tag, "_wr_en"}, 32'(fb_wr_en), 0);
    chk({tag, "_swap_req"}, 32'(fb_swap_req), 0);
    chk({tag, "_ack"}, 32'(rast_pixel_ack), 0);
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
  endtask

  // Expect H*V clear writes in raster order, then DRAW with no pending pixel write.
  task automatic check_clear();
    for (int i = 0; i < H * V; i++) begin
      chk("clr_wr_en", 32'(fb_wr_en), 1);
      chk("clr_x", 32'(fb_wr_x), i % H);
      chk("clr_y", 32'(fb_wr_y), i / H);
      chk("clr_color", 32'(fb_wr_color), 0);
      chk("clr_busy", 32'(busy), 1);
      chk("clr_rast_en", 32'(rast_enable), 0);
      cyc();
    end
    chk("post_clr_rast_en", 32'(rast_enable), 1);
    chk("post_clr_wr_en", 32'(fb_wr_en), 0);
  endtask

  task automatic enter_draw();
    start_frame();
`ifdef FB_DRAW_CLEAR_EN
    check_clear();
`else
    chk("draw_rast_en", 32'(rast_enable), 1);
    chk("draw_busy", 32'(busy), 1);
    chk("draw_wr_en", 32'(fb_wr_en), 0);
`endif
  endtask

  // Present one pixel, check the same-cycle ack, and clock it in.
  task automatic send(input int x, input int y, input int c, input logic done);
    rast_pixel_rdy = 1'b1;
    rast_x = X_W'(x);
    rast_y = Y_W'(y);
    rast_color = COLOR_W'(c);
    rast_done = done;
    if (x < H && y < V) exp_q.push_back({X_W'(x), Y_W'(y), COLOR_W'(c)});
    #1;
    chk("ack", 32'(rast_pixel_ack), 1);
    cyc();
    rast_done = 1'b0;
  endtask

  task automatic check_wr();
    logic [X_W+Y_W+COLOR_W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pix_wr_en", 32'(fb_wr_en), 1);
      chk("pix_wr_x", 32'(fb_wr_x), 32'(e[X_W+Y_W+COLOR_W-1 -: X_W]));
      chk("pix_wr_y", 32'(fb_wr_y), 32'(e[Y_W+COLOR_W-1 -: Y_W]));
      chk("pix_wr_color", 32'(fb_wr_color), 32'(e[COLOR_W-1:0]));
    end else begin
      chk("pix_no_wr", 32'(fb_wr_en), 0);
    end
  endtask

  initial begin
    // Reset dominates live inputs.
    frame_start = 1'b1;
    rast_pixel_rdy = 1'b1;
    rast_x = 10'd1;
    repeat (3) cyc();
    chk_idle_outputs("reset");
    chk("reset_oob", 32'(oob_err), 0);
    chk("reset_wr_x", 32'(fb_wr_x), 0);
    rst_n = 1'b1;
    frame_start = 1'b0;
    rast_pixel_rdy = 1'b0;
    cyc();
    chk_idle_outputs("idle");

    // Frame 1: draw, out-of-range pixels, done with a final pixel, swap.
    enter_draw();
    #1;
    chk("ack_no_rdy", 32'(rast_pixel_ack), 0);
    send(1, 1, 5, 1'b0); check_wr();
    send(2, 1, 6, 1'b0); check_wr();
    send(3, 0, 3, 1'b0); check_wr();
    rast_pixel_rdy = 1'b0;
    cyc(); check_wr();
    send(640, 0, 1, 1'b0); check_wr();
    chk("oob_set", 32'(oob_err), 1);
    send(4, 0, 2, 1'b0); check_wr();
    send(0, 2, 2, 1'b0); check_wr();
    send(3, 1, 7, 1'b0); check_wr();
    send(2, 0, 6, 1'b1);
    rast_pixel_rdy = 1'b0;
    check_wr();
    chk("swap_req_up", 32'(fb_swap_req), 1);
    chk("swap_rast_en", 32'(rast_enable), 0);
    chk("swap_busy", 32'(busy), 1);
    rast_pixel_rdy = 1'b1;
    #1;
    chk("swap_ack", 32'(rast_pixel_ack), 0);
    rast_pixel_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("swap_req_hold", 32'(fb_swap_req), 1);
      chk("swap_no_wr", 32'(fb_wr_en), 0);
    end
    fb_swap_done = 1'b1;
    cyc();
    fb_swap_done = 1'b0;
    chk_idle_outputs("after_swap");
    fb_swap_done = 1'b1;
    cyc();
    fb_swap_done = 1'b0;
    cyc();
    chk("idle_swap_done_ignored", 32'(busy), 0);
    chk("oob_sticky1", 32'(oob_err), 1);

    // Frame 2: two starts during DRAW give exactly one more frame.
    enter_draw();
    start_frame();
    cyc();
    start_frame();
    chk("pend_still_draw", 32'(rast_enable), 1);
    rast_done = 1'b1;
    cyc();
    rast_done = 1'b0;
    chk("pend_swap_req", 32'(fb_swap_req), 1);
    check_wr();
    fb_swap_done = 1'b1;
    cyc();
    fb_swap_done = 1'b0;
    chk("pend_swap_req_drop", 32'(fb_swap_req), 0);
`ifdef FB_DRAW_CLEAR_EN
    check_clear();
`else
    chk("pend_redraw", 32'(rast_enable), 1);
    chk("pend_busy", 32'(busy), 1);
`endif
    rast_done = 1'b1;
    cyc();
    rast_done = 1'b0;
    chk("pend2_swap_req", 32'(fb_swap_req), 1);
    fb_swap_done = 1'b1;
    cyc();
    fb_swap_done = 1'b0;
    chk_idle_outputs("second_pulse_lost");
    chk("oob_sticky2", 32'(oob_err), 1);

    // Reset in the middle of a frame, then restart.
`ifdef FB_DRAW_CLEAR_EN
    start_frame();
    cyc();
    cyc();
    chk("mid_clear_x", 32'(fb_wr_x), 2);
    rst_n = 1'b0;
    cyc();
    chk_idle_outputs("mid_reset");
    chk("mid_reset_oob", 32'(oob_err), 0);
    chk("mid_reset_x", 32'(fb_wr_x), 0);
    rst_n = 1'b1;
    start_frame();
    check_clear();
`else
    enter_draw();
    rst_n = 1'b0;
    cyc();
    chk_idle_outputs("mid_reset");
    chk("mid_reset_oob", 32'(oob_err), 0);
    rst_n = 1'b1;
    start_frame();
    chk("restart_rast_en", 32'(rast_enable), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
